decimal_entry_accumulator: RTL

//  Upstream feeder for the 14-bit holding register: turns keypad digit presses into a 14-bit binary value.

---
 rtl/decimal_entry_accumulator.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/decimal_entry_accumulator.sv
// -----------------------------------------------------------------------------
// decimal_entry_accumulator
//
// Purpose:
//   Turns keypad presses into a binary value for a downstream holding register.
//   The block accepts up to MAX_DIGITS decimal digits and supports backspace and
//   clear-entry. On commit, it holds the accumulated value on `value` and raises
//   `enter` for exactly one cycle. The next cycle returns the entry to empty.
//
// Parameters:
//   WIDTH       width of value; must be able to hold 10**MAX_DIGITS-1
//   MAX_DIGITS  maximum decimal digits accepted per entry (fits in 3 bits)
//
// Ports:
//   clk          in   1      system clock, all logic on posedge
//   clr_n        in   1      synchronous active-low reset
//   digit        in   4      BCD digit code, used when a digit_key press is seen
//   digit_key    in   1      digit key level (held while pressed)
//   bksp_key     in   1      backspace key level
//   clear_key    in   1      clear-entry key level
//   commit_key   in   1      commit key level
//   value        out  WIDTH  current accumulated value (drives register D)
//   enter        out  1      one-cycle commit strobe (drives register enter)
//   digit_count  out  3      digits currently held, 0..MAX_DIGITS
//   err          out  1      one-cycle strobe: digit rejected (code>9 or full)
//   dbg_state    out  2      current FSM state (0 IDLE, 1 ENTRY, 2 FULL, 3 COMMIT)
//
// Handshake:
//   There is no valid/ready flow control.
//   - Keys are level inputs. Each key acts once, on the cycle its level is
//     first seen high.
//   - `enter` is a single-cycle strobe and the consumer cannot stall it.
//     `value` is stable during that cycle and is cleared on the following cycle.
// -----------------------------------------------------------------------------
module decimal_entry_accumulator #(
    parameter int WIDTH      = 14,
    parameter int MAX_DIGITS = 4
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic [3:0]       digit,
    input  logic             digit_key,
    input  logic             bksp_key,
    input  logic             clear_key,
    input  logic             commit_key,
    output logic [WIDTH-1:0] value,
    output logic             enter,
    output logic [2:0]       digit_count,
    output logic             err,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ENTRY  = 2'd1,
        ST_FULL   = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    localparam int         EXT_W   = WIDTH + 4;
    localparam logic [2:0] MAX_CNT = 3'(MAX_DIGITS);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t           r_state;
    logic [WIDTH-1:0] r_value;
    logic [2:0]       r_count;
    logic             r_enter;
    logic             r_err;

    // Key history: the level seen on the previous edge.
    logic             r_digit_hist;
    logic             r_bksp_hist;
    logic             r_clear_hist;
    logic             r_commit_hist;

    // ------------------------------------------------------------------
    // Key events: the level is high now but was low on the previous edge
    // ------------------------------------------------------------------
    logic w_digit_ev;
    logic w_bksp_ev;
    logic w_clear_ev;
    logic w_commit_ev;

    assign w_digit_ev  = digit_key  & ~r_digit_hist;
    assign w_bksp_ev   = bksp_key   & ~r_bksp_hist;
    assign w_clear_ev  = clear_key  & ~r_clear_hist;
    assign w_commit_ev = commit_key & ~r_commit_hist;

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    logic             w_digit_ok;
    logic [WIDTH-1:0] w_appended;
    logic [WIDTH-1:0] w_div10;
    logic [2:0]       w_cnt_inc;
    logic [2:0]       w_cnt_dec;

    assign w_digit_ok = (digit <= 4'd9);

    // value*10 + digit is formed as (v<<3)+(v<<1)+d in a widened word, then
    // truncated. The FULL state stops the result from ever exceeding
    // 10**MAX_DIGITS-1, so the truncation never loses significant bits.
    assign w_appended = WIDTH'(({{4{1'b0}}, r_value} << 3)
                             + ({{4{1'b0}}, r_value} << 1)
                             + EXT_W'(digit));

    assign w_div10   = r_value / WIDTH'(10);
    assign w_cnt_inc = r_count + 3'd1;
    assign w_cnt_dec = r_count - 3'd1;

    // ------------------------------------------------------------------
    // FSM with registered outputs
    // Same-cycle priority is clear > commit > backspace > digit.
    // Only the highest-priority event present is considered. The others are
    // discarded, even when that event turns out to be a no-op (for example,
    // commit while IDLE).
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            r_state       <= ST_IDLE;
            r_value       <= '0;
            r_count       <= 3'd0;
            r_enter       <= 1'b0;
            r_err         <= 1'b0;
            // Reset the history high so that a key held through reset does
            // not act when reset is released.
            r_digit_hist  <= 1'b1;
            r_bksp_hist   <= 1'b1;
            r_clear_hist  <= 1'b1;
            r_commit_hist <= 1'b1;
        end else begin
            // History is tracked every cycle, in every state, including COMMIT.
            r_digit_hist  <= digit_key;
            r_bksp_hist   <= bksp_key;
            r_clear_hist  <= clear_key;
            r_commit_hist <= commit_key;

            // Both strobes default low, so each one lasts a single cycle.
            r_enter <= 1'b0;
            r_err   <= 1'b0;

            if (r_state == ST_COMMIT) begin
                // The value was held for the enter cycle. Start a fresh entry.
                // Any key events seen in this cycle are dropped.
                r_state <= ST_IDLE;
                r_value <= '0;
                r_count <= 3'd0;
            end else if (w_clear_ev) begin
                r_state <= ST_IDLE;
                r_value <= '0;
                r_count <= 3'd0;
            end else if (w_commit_ev) begin
                if (r_state != ST_IDLE) begin
                    r_state <= ST_COMMIT;
                    r_enter <= 1'b1;
                end
            end else if (w_bksp_ev) begin
                if (r_state != ST_IDLE) begin
                    r_value <= w_div10;
                    r_count <= w_cnt_dec;
                    r_state <= (w_cnt_dec == 3'd0) ? ST_IDLE : ST_ENTRY;
                end
            end else if (w_digit_ev) begin
                if (!w_digit_ok || (r_state == ST_FULL)) begin
                    r_err <= 1'b1;
                end else begin
                    // A leading zero still uses up a digit slot: the count
                    // rises even though the value stays 0.
                    r_value <= w_appended;
                    r_count <= w_cnt_inc;
                    r_state <= (w_cnt_inc == MAX_CNT) ? ST_FULL : ST_ENTRY;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign value       = r_value;
    assign enter       = r_enter;
    assign digit_count = r_count;
    assign err         = r_err;
    assign dbg_state   = r_state;

endmodule
